// File: rtl/ntt_pkg.sv
// Shared types for the NTT datapath: word width, coefficient word,
// full-width product and the one-bit-wider word used for reduction.
package ntt_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0]   coeff_t;
   typedef logic [2*DATA_W-1:0] prod_t;
   typedef logic [DATA_W:0]     red_t;

endpackage

// File: rtl/ntt_butterfly_core_if.sv
// Butterfly operand/result bundle. The master side (the NTT engine)
// drives operands and modulus. The slave side (the core) returns the pair.
interface ntt_butterfly_core_if;
   import ntt_pkg::*;

   coeff_t cin_a;
   coeff_t cin_b;
   coeff_t w;
   coeff_t wp;
   coeff_t q;
   coeff_t cout_a;
   coeff_t cout_b;

   modport master (
      output cin_a, cin_b, w, wp, q,
      input  cout_a, cout_b
   );

   modport slave (
      input  cin_a, cin_b, w, wp, q,
      output cout_a, cout_b
   );

endinterface

// File: rtl/shoup_modmul.sv
// Combinational Shoup modular multiply: t = (w*b) mod q, with the
// precomputed wp = floor(w*2^DATA_W/q). Only the low DATA_W+1 bits of the
// exact product and of qhat*q are needed, because the true remainder
// estimate is known to lie in [0, 2q).
module shoup_modmul
   import ntt_pkg::*;
(
   input  coeff_t b,
   input  coeff_t w,
   input  coeff_t wp,
   input  coeff_t q,
   output coeff_t t
);

   prod_t  hi_prod;
   prod_t  wb_prod;
   prod_t  qq_prod;
   coeff_t qhat;
   red_t   r;
   red_t   q_ext;

   // Quotient estimate, remainder in [0,2q), then one conditional subtract
   always_comb begin
      hi_prod = prod_t'(wp) * prod_t'(b);
      qhat    = coeff_t'(hi_prod >> DATA_W);
      wb_prod = prod_t'(w) * prod_t'(b);
      qq_prod = prod_t'(qhat) * prod_t'(q);
      r       = red_t'(wb_prod - qq_prod);
      q_ext   = {1'b0, q};
      t       = (r >= q_ext) ? coeff_t'(r - q_ext) : coeff_t'(r);
   end

endmodule

// File: rtl/ntt_butterfly_core.sv
// Radix-2 Cooley-Tukey butterfly: (a + w*b) mod q and (a - w*b) mod q.
// One pair per clock, one-cycle latency, outputs fully reduced to [0, q-1].
// The output registers are the only state in the block.
module ntt_butterfly_core
   import ntt_pkg::*;
(
   input  logic clk,
   input  logic reset,
   ntt_butterfly_core_if.slave bus
);

   coeff_t t;
   red_t   q_ext;
   red_t   sum;
   red_t   diff;
   coeff_t cout_a_next;
   coeff_t cout_b_next;
   coeff_t cout_a_reg;
   coeff_t cout_b_reg;

   shoup_modmul u_modmul (
      .b  (bus.cin_b),
      .w  (bus.w),
      .wp (bus.wp),
      .q  (bus.q),
      .t  (t)
   );

   // Modular add and subtract of the reduced product against a
   always_comb begin
      q_ext       = {1'b0, bus.q};
      sum         = {1'b0, bus.cin_a} + {1'b0, t};
      diff        = {1'b0, bus.cin_a} - {1'b0, t};
      cout_a_next = (sum >= q_ext) ? coeff_t'(sum - q_ext) : coeff_t'(sum);
      cout_b_next = (bus.cin_a >= t) ? coeff_t'(diff) : coeff_t'(diff + q_ext);
   end

   // Output registers, cleared immediately while reset is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cout_a_reg <= '0;
         cout_b_reg <= '0;
      end else begin
         cout_a_reg <= cout_a_next;
         cout_b_reg <= cout_b_next;
      end
   end

   assign bus.cout_a = cout_a_reg;
   assign bus.cout_b = cout_b_reg;

endmodule

// File: tb/tb_ntt_butterfly_core.sv
// Directed and streaming bench for ntt_butterfly_core. Expected results come
// from a plain 64-bit mod reference. They are queued when operands are driven
// and popped when the registered result appears.
module tb_ntt_butterfly_core;
   import ntt_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;

   ntt_butterfly_core_if bus ();

   ntt_butterfly_core dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   coeff_t exp_a_q[$];
   coeff_t exp_b_q[$];

   localparam coeff_t Q_SMALL  = 32'd17;
   localparam coeff_t Q_STREAM = 32'h3FFF_FFFB;

   task automatic check(input string tag, input coeff_t obs, input coeff_t expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic coeff_t calc_wp(input coeff_t wv, input coeff_t qv);
      logic [63:0] num;
      logic [63:0] quo;
      num = {wv, 32'd0};
      quo = num / {32'd0, qv};
      return quo[31:0];
   endfunction

   function automatic coeff_t ref_add(input coeff_t a, input coeff_t b, input coeff_t wv, input coeff_t qv);
      logic [63:0] prod;
      logic [63:0] res;
      prod = ({32'd0, wv} * {32'd0, b}) % {32'd0, qv};
      res  = ({32'd0, a} + prod) % {32'd0, qv};
      return res[31:0];
   endfunction

   function automatic coeff_t ref_sub(input coeff_t a, input coeff_t b, input coeff_t wv, input coeff_t qv);
      logic [63:0] prod;
      logic [63:0] res;
      prod = ({32'd0, wv} * {32'd0, b}) % {32'd0, qv};
      res  = ({32'd0, a} + {32'd0, qv} - prod) % {32'd0, qv};
      return res[31:0];
   endfunction

   // Drive one butterfly, queue its expectation, then compare after the edge.
   task automatic step(input string tag, input coeff_t a, input coeff_t b,
                       input coeff_t wv, input coeff_t wpv, input coeff_t qv);
      coeff_t ea;
      coeff_t eb;
      bus.cin_a = a;
      bus.cin_b = b;
      bus.w     = wv;
      bus.wp    = wpv;
      bus.q     = qv;
      exp_a_q.push_back(ref_add(a, b, wv, qv));
      exp_b_q.push_back(ref_sub(a, b, wv, qv));
      @(posedge clk);
      #1;
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      $display("txn %s a=%0d b=%0d w=%0d -> cout_a=%0d cout_b=%0d (want %0d %0d)",
               tag, a, b, wv, bus.cout_a, bus.cout_b, ea, eb);
      check({tag, "_a"}, bus.cout_a, ea);
      check({tag, "_b"}, bus.cout_b, eb);
   endtask

   task automatic toggle_inputs(input coeff_t qv);
      bus.cin_a = $urandom_range(qv - 1, 0);
      bus.cin_b = $urandom_range(qv - 1, 0);
      bus.w     = $urandom_range(qv - 1, 0);
      bus.wp    = calc_wp(bus.w, qv);
      bus.q     = qv;
   endtask

   initial begin
      coeff_t ra;
      coeff_t rb;
      coeff_t rw;

      // Reset held: outputs stay zero while inputs toggle
      reset = 1'b0;
      toggle_inputs(Q_SMALL);
      #1;
      check("rst_init_a", bus.cout_a, 32'd0);
      check("rst_init_b", bus.cout_b, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_hold%0d_a", i), bus.cout_a, 32'd0);
         check($sformatf("rst_hold%0d_b", i), bus.cout_b, 32'd0);
         toggle_inputs(Q_SMALL);
      end

      // Release mid-cycle: nothing appears before the next edge
      reset = 1'b1;
      #1;
      check("rel_a", bus.cout_a, 32'd0);
      check("rel_b", bus.cout_b, 32'd0);

      // Directed cases, q = 17
      step("basic",      32'd3,  32'd5, 32'd4,  32'd1010580540, Q_SMALL);
      step("negwrap",    32'd0,  32'd1, 32'd16, 32'd4042322160, Q_SMALL);
      step("w_zero",     32'd9,  32'd7, 32'd0,  32'd0,          Q_SMALL);
      step("b_zero",     32'd9,  32'd0, 32'd5,  32'd1263225675, Q_SMALL);
      step("w_one_sumq", 32'd16, 32'd1, 32'd1,  calc_wp(32'd1, Q_SMALL), Q_SMALL);
      step("top_vals",   32'd16, 32'd16, 32'd16, calc_wp(32'd16, Q_SMALL), Q_SMALL);

      // Back-to-back random stream with a mid-stream reset
      for (int i = 0; i < 1024; i++) begin
         if (i == 512) begin
            reset = 1'b0;
            #1;
            check("mid_async_a", bus.cout_a, 32'd0);
            check("mid_async_b", bus.cout_b, 32'd0);
            for (int k = 0; k < 2; k++) begin
               toggle_inputs(Q_STREAM);
               @(posedge clk);
               #1;
               check($sformatf("mid_hold%0d_a", k), bus.cout_a, 32'd0);
               check($sformatf("mid_hold%0d_b", k), bus.cout_b, 32'd0);
            end
            reset = 1'b1;
            #1;
            check("mid_rel_a", bus.cout_a, 32'd0);
            check("mid_rel_b", bus.cout_b, 32'd0);
         end
         ra = $urandom_range(Q_STREAM - 1, 0);
         rb = $urandom_range(Q_STREAM - 1, 0);
         rw = $urandom_range(Q_STREAM - 1, 0);
         step($sformatf("stream%0d", i), ra, rb, rw, calc_wp(rw, Q_STREAM), Q_STREAM);
      end

      // Large-modulus edge operands
      step("big_max", Q_STREAM - 1, Q_STREAM - 1, Q_STREAM - 1,
           calc_wp(Q_STREAM - 1, Q_STREAM), Q_STREAM);
      step("big_wone", Q_STREAM - 1, 32'd1, 32'd1, calc_wp(32'd1, Q_STREAM), Q_STREAM);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
